// File: rtl/fsk_mod_pkg.sv
// ============================================================================
// fsk_mod_pkg : shared types, constants and code helpers for the FSK/ASK
//               symbol sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package fsk_mod_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int CODE_W    = 4;
    localparam logic [CODE_W-1:0] ZERO_CODE_SUB = 4'b0001;

    // freqDiv cannot run from an all-zero code
    function automatic logic [CODE_W-1:0] legal_code(input logic [CODE_W-1:0] code);
        return (code == '0) ? ZERO_CODE_SUB : code;
    endfunction

    // Returns {tx_en, code} for one symbol carrying bit value b
    function automatic logic [CODE_W:0] symbol_out(input logic              ask,
                                                   input logic [CODE_W-1:0] f0,
                                                   input logic [CODE_W-1:0] f1,
                                                   input logic              b);
        if (ask)
            return {b, f1};
        else
            return {1'b1, b ? f1 : f0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sym_timer.sv
// ============================================================================
// sym_timer : symbol-period down-counter; reloaded on each load strobe,
//             flags the last and next-to-last cycle of the symbol.
// Rev 1.0
// ============================================================================
`default_nettype none

module sym_timer #(
    parameter int SYM_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic sym_end,
    output logic sym_near_end
);

    localparam int TW = $clog2(SYM_CYCLES);
    localparam logic [TW-1:0] c_reload = TW'(SYM_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (reload)
            r_cnt <= c_reload;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - TW'(1);
    end

    assign sym_end      = (r_cnt == '0);
    assign sym_near_end = (r_cnt == TW'(1));

endmodule

`default_nettype wire

// File: rtl/fsk_symbol_sequencer.sv
// ============================================================================
// fsk_symbol_sequencer : frames bytes as start + 8 LSB-first data + stop
//                        symbols and drives freqDiv codes (FSK or ASK).
// Optional parity symbol when FSK_PARITY_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module fsk_symbol_sequencer
    import fsk_mod_pkg::*;
#(
    parameter int                SYM_CYCLES = 1024,
    parameter logic [CODE_W-1:0] IDLE_CODE  = 4'b1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [CODE_W-1:0] f0_code,
    input  logic [CODE_W-1:0] f1_code,
    output logic              msb,
    output logic [2:0]        cnt,
    output logic              load,
    output logic              tx_en,
    output logic              busy
);

    state_t              r_state, w_state;
    logic                r_mode, w_mode;
    logic [CODE_W-1:0]   r_f0, w_f0, r_f1, w_f1;
    logic [7:0]          r_shreg, w_shreg;
    logic [2:0]          r_bit_idx, w_bit_idx;
    logic [CODE_W-1:0]   r_code, w_code;
    logic                r_load, w_load, r_tx_en, w_tx_en;
    logic                r_busy, w_busy, r_in_ready, w_in_ready;
    logic                w_xfer, w_start, w_emit, w_bit;
    logic                w_sym_end, w_sym_near_end;
`ifdef FSK_PARITY_EN
    logic                r_parity, w_parity;
`endif

    sym_timer #(.SYM_CYCLES(SYM_CYCLES)) u_sym_timer (
        .clk          (clk),
        .rst          (rst),
        .reload       (w_load),
        .sym_end      (w_sym_end),
        .sym_near_end (w_sym_near_end)
    );

    assign w_xfer = in_valid & r_in_ready;

    always_comb begin
        w_state   = r_state;
        w_mode    = r_mode;
        w_f0      = r_f0;
        w_f1      = r_f1;
        w_shreg   = r_shreg;
        w_bit_idx = r_bit_idx;
        w_code    = r_code;
        w_tx_en   = r_tx_en;
        w_busy    = r_busy;
        w_load    = 1'b0;
        w_start   = 1'b0;
        w_emit    = 1'b0;
        w_bit     = 1'b1;
`ifdef FSK_PARITY_EN
        w_parity  = r_parity;
`endif
        case (r_state)
            IDLE: w_start = w_xfer;
            START: if (w_sym_end) begin
                w_state   = DATA;
                w_bit_idx = 3'd0;
                w_emit    = 1'b1;
                w_bit     = r_shreg[0];
                w_shreg   = r_shreg >> 1;
            end
            DATA: if (w_sym_end) begin
                w_emit = 1'b1;
                if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef FSK_PARITY_EN
                    w_state = PARITY;
                    w_bit   = r_parity;
`else
                    w_state = STOP;
`endif
                end else begin
                    w_bit_idx = r_bit_idx + 3'd1;
                    w_bit     = r_shreg[0];
                    w_shreg   = r_shreg >> 1;
                end
            end
`ifdef FSK_PARITY_EN
            PARITY: if (w_sym_end) begin
                w_state = STOP;
                w_emit  = 1'b1;
            end
`endif
            STOP: if (w_sym_end) begin
                // in_ready is only high here on the final cycle, so a transfer
                // chains straight into the next frame on the same symbol grid
                if (w_xfer) begin
                    w_start = 1'b1;
                end else begin
                    w_state = IDLE;
                    w_load  = 1'b1;
                    w_code  = IDLE_CODE;
                    w_tx_en = 1'b0;
                    w_busy  = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase

        if (w_emit) begin
            w_load            = 1'b1;
            {w_tx_en, w_code} = symbol_out(r_mode, r_f0, r_f1, w_bit);
        end

        if (w_start) begin
            w_state           = START;
            w_mode            = mode;
            w_f0              = legal_code(f0_code);
            w_f1              = legal_code(f1_code);
            w_shreg           = in_data;
            w_load            = 1'b1;
            w_busy            = 1'b1;
            {w_tx_en, w_code} = symbol_out(mode, legal_code(f0_code), legal_code(f1_code), 1'b0);
`ifdef FSK_PARITY_EN
            w_parity          = ^in_data;
`endif
        end

        w_in_ready = (w_state == IDLE) || (w_state == STOP && !w_load && w_sym_near_end);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            r_f0       <= ZERO_CODE_SUB;
            r_f1       <= ZERO_CODE_SUB;
            r_shreg    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_code     <= IDLE_CODE;
            r_load     <= 1'b0;
            r_tx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
`ifdef FSK_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_mode     <= w_mode;
            r_f0       <= w_f0;
            r_f1       <= w_f1;
            r_shreg    <= w_shreg;
            r_bit_idx  <= w_bit_idx;
            r_code     <= w_code;
            r_load     <= w_load;
            r_tx_en    <= w_tx_en;
            r_busy     <= w_busy;
            r_in_ready <= w_in_ready;
`ifdef FSK_PARITY_EN
            r_parity   <= w_parity;
`endif
        end
    end

    assign in_ready = r_in_ready;
    assign msb      = r_code[3];
    assign cnt      = r_code[2:0];
    assign load     = r_load;
    assign tx_en    = r_tx_en;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fsk_symbol_sequencer.sv
// ============================================================================
// tb_fsk_symbol_sequencer : directed table-driven bench for the sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fsk_symbol_sequencer;

    localparam int SYM = 16;
`ifdef FSK_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] f0_code = 4'd0;
    logic [3:0] f1_code = 4'd0;
    logic       in_ready, msb, load, tx_en, busy;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;

    fsk_symbol_sequencer #(.SYM_CYCLES(SYM), .IDLE_CODE(4'b1000)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .f0_code  (f0_code),
        .f1_code  (f1_code),
        .msb      (msb),
        .cnt      (cnt),
        .load     (load),
        .tx_en    (tx_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // codes: symbol i in nibble i; tx: symbol i in bit i (10-symbol frame)
    typedef struct {
        logic [7:0]  data;
        logic        mode;
        logic [3:0]  f0;
        logic [3:0]  f1;
        logic [39:0] codes;
        logic [9:0]  tx;
        logic [3:0]  par_code;
        logic        par_tx;
    } vec_t;

    vec_t vecs[5];
    vec_t v55, vaa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_sym(input vec_t v, input int i);
        int k;
        k = i;
`ifdef FSK_PARITY_EN
        if (i == 9) return {v.par_tx, v.par_code};
        if (i == 10) k = 9;
`endif
        return {v.tx[k], v.codes[4*k +: 4]};
    endfunction

    // Entered at the negedge where the START load is expected
    task automatic check_frame(input vec_t v, input bit chain);
        logic [4:0] e;
        for (int i = 0; i < NSYM; i++) begin
            e = exp_sym(v, i);
            chk("sym_load",  32'(load), 32'd1);
            chk("sym_code",  32'({msb, cnt}), 32'(e[3:0]));
            chk("sym_tx",    32'(tx_en), 32'(e[4]));
            chk("sym_busy",  32'(busy), 32'd1);
            chk("sym_ready", 32'(in_ready), 32'd0);
            for (int j = 1; j < SYM; j++) begin
                @(negedge clk);
                chk("hold_load",  32'(load), 32'd0);
                chk("hold_code",  32'({msb, cnt}), 32'(e[3:0]));
                chk("hold_ready", 32'(in_ready), 32'((i == NSYM - 1) && (j == SYM - 1)));
                if (chain && i == NSYM - 1 && j == SYM - 1) begin
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!chain) begin
            chk("idle_load",  32'(load), 32'd1);
            chk("idle_code",  32'({msb, cnt}), 32'h8);
            chk("idle_tx",    32'(tx_en), 32'd0);
            chk("idle_busy",  32'(busy), 32'd0);
            chk("idle_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            chk("idle_load_drop", 32'(load), 32'd0);
        end
    endtask

    // Entered and left at a negedge; leaves at the first-load negedge
    task automatic send(input vec_t v, input bit hold);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_data  = v.data;
        mode     = v.mode;
        f0_code  = v.f0;
        f1_code  = v.f1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            mode     = ~v.mode;
            f0_code  = 4'hF;
            f1_code  = 4'hE;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 4'h4, 4'h9, 40'h9949449494, 10'h3FF, 4'h4, 1'b1};
        vecs[1] = '{8'h0F, 1'b1, 4'h3, 4'h6, 40'h6666666666, 10'h21E, 4'h6, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 4'h0, 4'hC, 40'hC11CCCC111, 10'h3FF, 4'h1, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 4'h5, 4'h0, 40'h1111111111, 10'h302, 4'h1, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 4'h4, 4'h9, 40'h9444449994, 10'h3FF, 4'h9, 1'b1};
        v55     = '{8'h55, 1'b0, 4'h4, 4'h9, 40'h9494949494, 10'h3FF, 4'h4, 1'b1};
        vaa     = '{8'hAA, 1'b0, 4'h4, 4'h9, 40'h9949494944, 10'h3FF, 4'h4, 1'b1};

        // Reset
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_code",  32'({msb, cnt}), 32'h8);
        chk("rst_load",  32'(load), 32'd0);
        chk("rst_tx",    32'(tx_en), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Single frames
        for (int k = 0; k < 5; k++) begin
            send(vecs[k], 1'b0);
            check_frame(vecs[k], 1'b0);
        end

        // Back-to-back frames with in_valid held
        send(v55, 1'b1);
        in_data = 8'hAA;
        check_frame(v55, 1'b1);
        check_frame(vaa, 1'b0);

        // Reset in the middle of DATA
        send(vecs[0], 1'b0);
        repeat (3 * SYM + 5) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_code",  32'({msb, cnt}), 32'h8);
        chk("abort_load",  32'(load), 32'd0);
        chk("abort_tx",    32'(tx_en), 32'd0);
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rel_ready", 32'(in_ready), 32'd1);
        chk("abort_rel_load",  32'(load), 32'd0);
        chk("abort_rel_busy",  32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
